// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator
// Collects {co, sum} results from the 32-bit adder and sums N_TERMS of them
// (or fewer on flush) into a wide total. The total, its term count and a
// sticky overflow flag are presented through a one-deep output register.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. Input side: in_valid/in_ready, with in_ready depending only on
// the FSM state. Output side: out_valid/out_ready, with out_valid held and
// the result stable until out_ready is seen.
module adder_result_accumulator #(
  parameter int SUM_W   = 32,
  parameter int ACC_W   = 48,
  parameter int N_TERMS = 4,
  localparam int CNT_W  = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] sum,
  input  logic             co,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] acc_count,
  output logic             acc_ovf
);

  // ACCUM takes terms; DRAIN holds a result until the consumer takes it.
  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             accept;
  logic             emit;
  logic             carry;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] add_in;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_sum;

  // Zero-extend the adder result (carry included) to accumulator width.
  always_comb begin
    term = '0;
    term[SUM_W:0] = {co, sum};
  end

  // Ready is a pure function of state, so there is no path from out_ready.
  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;
  assign add_in   = accept ? term : '0;

  // One adder serves both the plain-accumulate and the emit cases.
  assign {carry, acc_sum} = {1'b0, acc} + {1'b0, add_in};
  assign cnt_sum          = cnt + CNT_W'(accept);

  // Emit on a full batch, or on flush when there is at least one term to send.
  assign emit = in_ready &&
                ((accept && (cnt_sum == CNT_W'(N_TERMS))) ||
                 (flush && ((cnt != '0) || accept)));

  // Batch state, FSM and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      acc_out   <= '0;
      acc_count <= '0;
      acc_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (emit) begin
            acc_out   <= acc_sum;
            acc_count <= cnt_sum;
            acc_ovf   <= ovf | carry;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            state     <= DRAIN;
          end else if (accept) begin
            acc <= acc_sum;
            cnt <= cnt_sum;
            ovf <= ovf | carry;
          end
        end
        DRAIN: begin
          // Result registers keep their values after the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed bench for adder_result_accumulator. A 48-bit and a 34-bit instance
// share the same inputs and run in lockstep; the 34-bit one shows wraparound.
module tb_adder_result_accumulator;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] sum;
  logic        co;
  logic        flush;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [47:0] acc_out;
  logic [2:0]  acc_count;
  logic        acc_ovf;

  logic        in_ready34;
  logic        out_valid34;
  logic [33:0] acc_out34;
  logic [2:0]  acc_count34;
  logic        acc_ovf34;

  int checks;
  int errors;

  adder_result_accumulator #(.SUM_W(32), .ACC_W(48), .N_TERMS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .co(co), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .acc_out(acc_out), .acc_count(acc_count),
    .acc_ovf(acc_ovf)
  );

  adder_result_accumulator #(.SUM_W(32), .ACC_W(34), .N_TERMS(4)) dut34 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready34),
    .sum(sum), .co(co), .flush(flush), .out_valid(out_valid34),
    .out_ready(out_ready), .acc_out(acc_out34), .acc_count(acc_count34),
    .acc_ovf(acc_ovf34)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one term and hold it until accepted (bounded wait).
  task automatic put(input logic c, input logic [31:0] s);
    int n;
    in_valid = 1'b1;
    co       = c;
    sum      = s;
    n        = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL put_ready_timeout in_ready got %0b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; sum = '0; co = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({out_valid, acc_out, acc_count, acc_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b acc=%0h cnt=%0d ovf=%0b want all 0",
               out_valid, acc_out, acc_count, acc_ovf);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    put(1'b0, 32'd1); put(1'b0, 32'd2); put(1'b0, 32'd3);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid got %0b want 0", out_valid);
    end
    put(1'b0, 32'd4);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 48'd10 || acc_count !== 3'd4 || acc_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got v=%0b acc=%0h cnt=%0d ovf=%0b want 1 a 4 0",
               out_valid, acc_out, acc_count, acc_ovf);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_bubble in_ready got %0b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || acc_out !== 48'd10) begin
      errors++;
      $display("FAIL basic_after_hs got v=%0b rdy=%0b acc=%0h want 0 1 a", out_valid, in_ready, acc_out);
    end
  endtask

  task automatic test_carry();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) put(1'b1, 32'hFFFF_FFFF);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 48'h7_FFFF_FFFC || acc_count !== 3'd4 || acc_ovf !== 1'b0) begin
      errors++;
      $display("FAIL carry_result got v=%0b acc=%0h cnt=%0d ovf=%0b want 1 7fffffffc 4 0",
               out_valid, acc_out, acc_count, acc_ovf);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    put(1'b0, 32'd5); put(1'b0, 32'd6); put(1'b0, 32'd7); put(1'b0, 32'd8);
    in_valid = 1'b1; co = 1'b0; sum = 32'd100;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || acc_out !== 48'd26 || acc_count !== 3'd4 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%0b acc=%0h cnt=%0d rdy=%0b want 1 1a 4 0",
                 i, out_valid, acc_out, acc_count, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got v=%0b rdy=%0b want 0 1", out_valid, in_ready);
    end
    put(1'b0, 32'd1); put(1'b0, 32'd2); put(1'b0, 32'd3); put(1'b0, 32'd4);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 48'd10 || acc_count !== 3'd4) begin
      errors++;
      $display("FAIL bp_next_batch got v=%0b acc=%0h cnt=%0d want 1 a 4", out_valid, acc_out, acc_count);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    put(1'b0, 32'd7); put(1'b0, 32'd9);
    flush = 1'b1; tick(); flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 48'd16 || acc_count !== 3'd2 || acc_ovf !== 1'b0) begin
      errors++;
      $display("FAIL flush_partial got v=%0b acc=%0h cnt=%0d ovf=%0b want 1 10 2 0",
               out_valid, acc_out, acc_count, acc_ovf);
    end
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty got v=%0b rdy=%0b want 0 1", out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty_late got v=%0b want 0", out_valid);
    end
    // flush together with a single term: one-term result
    flush = 1'b1; put(1'b0, 32'd20); flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 48'd20 || acc_count !== 3'd1) begin
      errors++;
      $display("FAIL flush_with_term got v=%0b acc=%0h cnt=%0d want 1 14 1", out_valid, acc_out, acc_count);
    end
    tick();
    // flush coincident with the completing 4th term
    put(1'b0, 32'd1); put(1'b0, 32'd2); put(1'b0, 32'd3);
    flush = 1'b1; put(1'b0, 32'd4); flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 48'd10 || acc_count !== 3'd4) begin
      errors++;
      $display("FAIL flush_full got v=%0b acc=%0h cnt=%0d want 1 a 4", out_valid, acc_out, acc_count);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full_single got v=%0b rdy=%0b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush_in_drain();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(1'b0, 32'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    out_ready = 1'b1; tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || acc_out !== 48'd4) begin
      errors++;
      $display("FAIL drain_flush_ignored got v=%0b acc=%0h want 0 4", out_valid, acc_out);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) put(1'b1, 32'hFFFF_FFFF);
    checks++;
    if (out_valid34 !== 1'b1 || acc_out34 !== 34'h3_FFFF_FFFC || acc_count34 !== 3'd4 || acc_ovf34 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_wrap got v=%0b acc=%0h cnt=%0d ovf=%0b want 1 3fffffffc 4 1",
               out_valid34, acc_out34, acc_count34, acc_ovf34);
    end
    tick();
    for (int i = 0; i < 4; i++) put(1'b0, 32'd1);
    checks++;
    if (out_valid34 !== 1'b1 || acc_out34 !== 34'd4 || acc_ovf34 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_cleared got v=%0b acc=%0h ovf=%0b want 1 4 0", out_valid34, acc_out34, acc_ovf34);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) put(1'b0, 32'd1);
    rst = 1'b1; #1;
    checks++;
    if ({out_valid, acc_out, acc_count, acc_ovf} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_batch got v=%0b acc=%0h cnt=%0d ovf=%0b rdy=%0b want 0 0 0 0 1",
               out_valid, acc_out, acc_count, acc_ovf, in_ready);
    end
    tick(); rst = 1'b0; tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(1'b0, 32'd2);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 48'd8) begin
      errors++;
      $display("FAIL rst_pre_drain got v=%0b acc=%0h want 1 8", out_valid, acc_out);
    end
    rst = 1'b1; #1;
    checks++;
    if ({out_valid, acc_out, acc_count, acc_ovf} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_drain got v=%0b acc=%0h cnt=%0d ovf=%0b rdy=%0b want 0 0 0 0 1",
               out_valid, acc_out, acc_count, acc_ovf, in_ready);
    end
    tick(); rst = 1'b0; out_ready = 1'b1; tick();
    for (int i = 0; i < 4; i++) put(1'b0, 32'd1);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 48'd4 || acc_count !== 3'd4 || acc_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_after_batch got v=%0b acc=%0h cnt=%0d ovf=%0b want 1 4 4 0",
               out_valid, acc_out, acc_count, acc_ovf);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_flush();
    test_flush_in_drain();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
